// File: rtl/if_stage.sv
// Fetch stage: PC register feeding the instruction ROM plus the IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched alongside a taken branch.
module if_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_exc_adel
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              id_exc_adel_q, id_exc_adel_d;

  // PC register; stall_id alone is illegal but still freezes fetch so both registers hold.
  always_comb begin
    pc_d = pc_q;
    ce_d = ce_q;
    if (!ce_q) begin
      ce_d = 1'b1;
    end else if (flush) begin
      pc_d = flush_pc;
    end else if (stall_if || stall_id) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // IF/ID register
  always_comb begin
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;
    id_valid_d    = id_valid_q;
    id_exc_adel_d = id_exc_adel_q;
    if (flush) begin
      id_pc_d       = '0;
      id_inst_d     = '0;
      id_valid_d    = 1'b0;
      id_exc_adel_d = 1'b0;
    end else if (stall_id) begin
      id_pc_d       = id_pc_q;
    end else if (stall_if || !ce_q) begin
      id_pc_d       = '0;
      id_inst_d     = '0;
      id_valid_d    = 1'b0;
      id_exc_adel_d = 1'b0;
    end else if (pc_q[1:0] != 2'b00) begin
      // Misaligned fetch: pass the address on so CP0 can report AdEL, but never the word.
      id_pc_d       = pc_q;
      id_inst_d     = '0;
      id_valid_d    = 1'b1;
      id_exc_adel_d = 1'b1;
`ifndef BRANCH_DELAY_SLOT_EN
    end else if (branch_flag) begin
      id_pc_d       = '0;
      id_inst_d     = '0;
      id_valid_d    = 1'b0;
      id_exc_adel_d = 1'b0;
`endif
    end else begin
      id_pc_d       = pc_q;
      id_inst_d     = inst_i;
      id_valid_d    = 1'b1;
      id_exc_adel_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ce_q          <= 1'b0;
      id_pc_q       <= '0;
      id_inst_q     <= '0;
      id_valid_q    <= 1'b0;
      id_exc_adel_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ce_q          <= ce_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
      id_valid_q    <= id_valid_d;
      id_exc_adel_q <= id_exc_adel_d;
    end
  end

  assign pc          = pc_q;
  assign ce          = ce_q;
  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign id_exc_adel = id_exc_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver predicts each edge's result from the stage rules,
// a monitor compares the DUT one time unit after every rising edge.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0, stall_id = 1'b0, flush = 1'b0, branch_flag = 1'b0;
  logic [31:0] flush_pc = '0, branch_target = '0;
  logic [31:0] inst_i;
  logic [31:0] pc, id_pc, id_inst;
  logic        ce, id_valid, id_exc_adel;

  int    tests = 0;
  int    fails = 0;
  snap_t exp_q[$];
  snap_t model;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_i = rom(pc);

  if_stage dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
    .flush_pc(flush_pc), .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_i(inst_i), .pc(pc), .ce(ce), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .id_exc_adel(id_exc_adel)
  );

  function automatic snap_t reset_state();
    snap_t s;
    s = '0;
    return s;
  endfunction

  // Reference: what one rising edge does to the visible state, given the current inputs.
  function automatic snap_t predict(input snap_t s, input logic sif, input logic sid,
                                    input logic fl, input logic [31:0] fpc,
                                    input logic br, input logic [31:0] bt);
    snap_t n;
    logic  take_word;
    n = s;
    if (!s.ce)          n.ce = 1'b1;
    else if (fl)        n.pc = fpc;
    else if (sif)       n.pc = s.pc;
    else if (br)        n.pc = bt;
    else                n.pc = s.pc + 32'd4;

`ifdef BRANCH_DELAY_SLOT_EN
    take_word = 1'b1;
`else
    take_word = !br;
`endif
    if (fl || (!sid && (sif || !s.ce))) begin
      n.id_pc = 0; n.id_inst = 0; n.id_valid = 0; n.id_adel = 0;
    end else if (!sid) begin
      if (s.pc % 4 != 0) begin
        n.id_pc = s.pc; n.id_inst = 0; n.id_valid = 1; n.id_adel = 1;
      end else if (take_word) begin
        n.id_pc = s.pc; n.id_inst = rom(s.pc); n.id_valid = 1; n.id_adel = 0;
      end else begin
        n.id_pc = 0; n.id_inst = 0; n.id_valid = 0; n.id_adel = 0;
      end
    end
    return n;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.pc = pc; s.ce = ce; s.id_pc = id_pc; s.id_inst = id_inst;
    s.id_valid = id_valid; s.id_adel = id_exc_adel;
    return s;
  endfunction

  task automatic compare(input string name, input snap_t act, input snap_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got pc=%h ce=%b id_pc=%h id_inst=%h v=%b adel=%b, expected pc=%h ce=%b id_pc=%h id_inst=%h v=%b adel=%b",
               name, act.pc, act.ce, act.id_pc, act.id_inst, act.id_valid, act.id_adel,
               exp.pc, exp.ce, exp.id_pc, exp.id_inst, exp.id_valid, exp.id_adel);
    end else begin
      $display("[TB] ok   %s: pc=%h ce=%b id_pc=%h id_inst=%h v=%b adel=%b",
               name, act.pc, act.ce, act.id_pc, act.id_inst, act.id_valid, act.id_adel);
    end
  endtask

  // Monitor: the DUT presents a new state after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) compare("edge", sample(), exp_q.pop_front());
    end
  end

  // Called in the low phase: drive, predict the coming edge, then wait past it.
  task automatic step(input logic sif, input logic sid, input logic fl, input logic [31:0] fpc,
                      input logic br, input logic [31:0] bt);
    snap_t n;
    stall_if = sif; stall_id = sid; flush = fl; flush_pc = fpc;
    branch_flag = br; branch_target = bt;
    n = predict(model, sif, sid, fl, fpc, br, bt);
    exp_q.push_back(n);
    model = n;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse in the low phase; outputs must clear before any edge.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 compare("async_reset", sample(), reset_state());
    model = reset_state();
    #1 rst = 1'b0;
  endtask

  initial begin
    model = reset_state();
    repeat (2) @(negedge clk);
    compare("reset_hold", sample(), reset_state());
    rst = 1'b0;

    idle(4);                                   // ce/pc ramp, pc reaches 0x0C
    step(0, 0, 0, 0, 1, 32'h40);               // branch while pc=0x0C
    idle(3);                                   // pc reaches 0x4C
    while (model.pc != 32'h10) step(0, 0, 1, 32'h10, 0, 0);
    step(1, 1, 0, 0, 0, 0);                    // freeze
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);                    // single bubble
    idle(1);
    step(1, 0, 1, 32'h80, 1, 32'h40);          // flush beats stall and branch
    idle(1);
    step(0, 0, 0, 0, 1, 32'h42);               // misaligned target
    idle(2);
    step(0, 0, 1, 32'h20, 0, 0);
    pulse_reset();                             // reset mid-cycle at pc=0x20
    idle(4);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8);        // wrap past the top of memory
    idle(3);

    for (int i = 0; i < 400; i++) begin
      logic        sif, sid, fl, br;
      logic [31:0] fpc, bt;
      sif = ($urandom_range(0, 4) == 0);
      sid = sif && ($urandom_range(0, 1) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      br  = ($urandom_range(0, 5) == 0);
      fpc = {24'h0, 6'($urandom), 2'b00};
      bt  = {24'h0, 6'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(sif, sid, fl, fpc, br, bt);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
